// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the decryption datapath.
package aes_pkg;

   localparam int unsigned NR = 10;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   typedef enum logic [1:0] {
      StIdle = IDLE,
      StRun  = RUN,
      StDone = DONE
   } state_e;

   localparam logic [7:0] INV_SBOX [0:255] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   // Multiply by x modulo x^8 + x^4 + x^3 + x + 1 (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gmul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gmul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gmul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (skipped when last).
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [0:127] state_in,
   input  logic [0:127] round_key,
   input  logic         last,
   output logic [0:127] state_out
);

   logic [7:0] ak [16];
   logic [7:0] mc [16];

   // Byte k sits at row k%4, col k/4; InvShiftRows rotates row r right by r.
   for (genvar k = 0; k < 16; k++) begin : g_byte
      localparam int unsigned Row = k % 4;
      localparam int unsigned Col = k / 4;
      localparam int unsigned Src = Row + 4 * ((Col + 4 - Row) % 4);
      assign ak[k] = INV_SBOX[state_in[8*Src +: 8]] ^ round_key[8*k +: 8];
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ak[4*c + 0];
      assign a1 = ak[4*c + 1];
      assign a2 = ak[4*c + 2];
      assign a3 = ak[4*c + 3];
      assign mc[4*c + 0] = gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3);
      assign mc[4*c + 1] = gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3);
      assign mc[4*c + 2] = gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3);
      assign mc[4*c + 3] = gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3);
   end

   // Final round bypasses InvMixColumns.
   always_comb begin
      state_out = '0;
      for (int k = 0; k < 16; k++) begin
         state_out[8*k +: 8] = last ? ak[k] : mc[k];
      end
   end

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, valid/ready on both sides.
module aes_decrypt_iter
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [0:127] cipher_data,
   input  logic [0:127] key_0,
   input  logic [0:127] key_1,
   input  logic [0:127] key_2,
   input  logic [0:127] key_3,
   input  logic [0:127] key_4,
   input  logic [0:127] key_5,
   input  logic [0:127] key_6,
   input  logic [0:127] key_7,
   input  logic [0:127] key_8,
   input  logic [0:127] key_9,
   input  logic [0:127] key_10,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [0:127] clear_data
);

   state_e       state_q;
   logic [3:0]   rnd_q;
   logic [0:127] state_reg_q;
   logic         in_ready_q;
   logic         out_valid_q;

   logic [0:127] round_key;
   logic [0:127] round_out;
   logic         last;

   assign last = (rnd_q == 4'd0);

   // Round-key mux; key_10 is only used at accept time.
   always_comb begin
      round_key = key_0;
      case (rnd_q)
         4'd1:    round_key = key_1;
         4'd2:    round_key = key_2;
         4'd3:    round_key = key_3;
         4'd4:    round_key = key_4;
         4'd5:    round_key = key_5;
         4'd6:    round_key = key_6;
         4'd7:    round_key = key_7;
         4'd8:    round_key = key_8;
         4'd9:    round_key = key_9;
         default: round_key = key_0;
      endcase
   end

   aes_inv_round u_round (
      .state_in  (state_reg_q),
      .round_key (round_key),
      .last      (last),
      .state_out (round_out)
   );

   // Control FSM with registered handshake outputs; in_ready stays low through reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         rnd_q       <= 4'd0;
         state_reg_q <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  state_reg_q <= cipher_data ^ key_10;
                  rnd_q       <= 4'(NR - 1);
                  state_q     <= StRun;
                  in_ready_q  <= 1'b0;
               end else begin
                  in_ready_q  <= 1'b1;
               end
            end
            StRun: begin
               state_reg_q <= round_out;
               if (last) begin
                  state_q     <= StDone;
                  out_valid_q <= 1'b1;
               end else begin
                  rnd_q <= rnd_q - 4'd1;
               end
            end
            StDone: begin
               // No bypass: in_ready rises only once back in idle.
               if (out_ready) begin
                  state_q     <= StIdle;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= StIdle;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign clear_data = state_reg_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Bench for aes_decrypt_iter: FIPS-197 vectors, handshake corner cases and
// random loopback against a behavioural AES-128 encryptor.
module tb_aes_decrypt_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] cipher_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] clear_data;
   logic [127:0] rk [0:10];

   logic [7:0]   sbox [256];
   int           n_tests;
   int           n_fail;

   typedef struct {
      string        name;
      logic [127:0] key;
      logic [127:0] cipher;
      logic [127:0] plain;
   } vec_t;

   vec_t vecs [2];

   aes_decrypt_iter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .cipher_data (cipher_data),
      .key_0       (rk[0]),
      .key_1       (rk[1]),
      .key_2       (rk[2]),
      .key_3       (rk[3]),
      .key_4       (rk[4]),
      .key_5       (rk[5]),
      .key_6       (rk[6]),
      .key_7       (rk[7]),
      .key_8       (rk[8]),
      .key_9       (rk[9]),
      .key_10      (rk[10]),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .clear_data  (clear_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   // Forward S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
             ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
         sbox[x] = s;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rcon;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = gf_mul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Reference encryptor over the current round keys; byte k = row k%4, col k/4.
   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a [4];
      logic [127:0] key;
      logic [127:0] res;
      key = rk[0];
      for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ key[127-8*k -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
         for (int k = 0; k < 16; k++) s[k] = t[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
               s[4*c+0] = gf_mul(a[0], 8'h02) ^ gf_mul(a[1], 8'h03) ^ a[2] ^ a[3];
               s[4*c+1] = a[0] ^ gf_mul(a[1], 8'h02) ^ gf_mul(a[2], 8'h03) ^ a[3];
               s[4*c+2] = a[0] ^ a[1] ^ gf_mul(a[2], 8'h02) ^ gf_mul(a[3], 8'h03);
               s[4*c+3] = gf_mul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gf_mul(a[3], 8'h02);
            end
         end
         key = rk[rnd];
         for (int k = 0; k < 16; k++) s[k] = s[k] ^ key[127-8*k -: 8];
      end
      res = '0;
      for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
      return res;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at #1 after an edge; returns #1 after the accept edge.
   task automatic accept(input logic [127:0] ct, input string name, output bit ok);
      int n;
      cipher_data = ct;
      in_valid    = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok = in_ready;
      if (!ok) begin
         check({name, " accept timeout"}, 128'(in_ready), 128'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Counts cycles from accept to out_valid and checks latency and data.
   task automatic wait_result(input logic [127:0] exp, input string name);
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, " latency"}, 128'(n), 128'd10);
      check({name, " data"}, clear_data, exp);
   endtask

   task automatic run_block(input logic [127:0] ct, input logic [127:0] exp, input int hold,
                            input string name);
      bit ok;
      accept(ct, name, ok);
      if (!ok) return;
      wait_result(exp, name);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " handshake"}, {126'd0, out_valid, in_ready}, 128'b01);
   endtask

   initial begin
      bit           ok;
      int           bad;
      int           idx;
      int           acc [2];
      bit           pending;
      logic [127:0] cts [2];
      logic [127:0] pt2;
      logic [127:0] pt;
      logic [127:0] got [$];

      n_tests     = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      cipher_data = '0;
      for (int r = 0; r < 11; r++) rk[r] = '0;

      vecs[0] = '{name: "fips_b", key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  cipher: 128'h3925841d02dc09fbdc118597196a0b32,
                  plain: 128'h3243f6a8885a308d313198a2e0370734};
      vecs[1] = '{name: "fips_c1", key: 128'h000102030405060708090a0b0c0d0e0f,
                  cipher: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                  plain: 128'h00112233445566778899aabbccddeeff};

      build_sbox();

      // Reset state
      #2;
      check("reset in_ready", 128'(in_ready), 128'd0);
      check("reset out_valid", 128'(out_valid), 128'd0);
      check("reset clear_data", clear_data, 128'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("release in_ready low", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
      check("release in_ready", 128'(in_ready), 128'd1);

      // Known-answer vectors
      for (int i = 0; i < 2; i++) begin
         expand(vecs[i].key);
         run_block(vecs[i].cipher, vecs[i].plain, i, vecs[i].name);
      end

      // Back-pressure: result held 20 cycles, stray in_valid ignored
      expand(vecs[0].key);
      accept(vecs[0].cipher, "bp", ok);
      if (ok) begin
         wait_result(vecs[0].plain, "bp");
         bad = 0;
         for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || clear_data !== vecs[0].plain) bad++;
            if (i == 5) begin
               cipher_data = vecs[1].cipher;
               in_valid    = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk); #1;
         end
         check("bp stable", 128'(bad), 128'd0);
         check("bp held data", clear_data, vecs[0].plain);
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         check("bp release", {126'd0, out_valid, in_ready}, 128'b01);
         repeat (3) @(posedge clk);
         #1;
         check("bp no capture", {126'd0, out_valid, in_ready}, 128'b01);
      end

      // Back-to-back: in_valid and out_ready held high, two blocks queued
      pt2    = rand128();
      cts[0] = vecs[0].cipher;
      cts[1] = encrypt(pt2);
      idx    = 0;
      acc[0] = -1;
      acc[1] = -1;
      cipher_data = cts[0];
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         pending = in_valid && in_ready;
         @(posedge clk); #1;
         if (pending) begin
            acc[idx] = cyc;
            idx++;
            if (idx == 2) in_valid = 1'b0;
            else cipher_data = cts[1];
         end
         if (out_valid) got.push_back(clear_data);
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("b2b accepts", 128'(idx), 128'd2);
      check("b2b interval", 128'(acc[1] - acc[0]), 128'd12);
      check("b2b outputs", 128'(got.size()), 128'd2);
      if (got.size() >= 2) begin
         check("b2b first", got[0], vecs[0].plain);
         check("b2b second", got[1], pt2);
      end

      // Mid-run reset at cycle 5 after accept
      expand(vecs[1].key);
      accept(vecs[1].cipher, "mid", ok);
      if (ok) begin
         repeat (4) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         check("mid rst out_valid", 128'(out_valid), 128'd0);
         check("mid rst clear_data", clear_data, 128'd0);
         check("mid rst in_ready", 128'(in_ready), 128'd0);
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
         check("mid release in_ready", {126'd0, out_valid, in_ready}, 128'b01);
         run_block(vecs[1].cipher, vecs[1].plain, 0, "post_rst");
      end

      // Loopback against the reference encryptor
      for (int i = 0; i < 1000; i++) begin
         expand(rand128());
         pt = rand128();
         run_block(encrypt(pt), pt, int'($urandom_range(0, 2)), "loopback");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
